// File: rtl/shift_pipe_if.sv
// Request/result handshake bundle for shift_pipe.
// The in_* group flows toward the shifter and the out_* group flows back.
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA) with valid/ready flow control and a tag sideband.
// Define SHIFT_PIPE_ROTATE_EN to make op 11 rotate right; otherwise op 11 behaves as SRL.
module shift_pipe #(
  parameter int WIDTH       = 32,
  parameter int LVL_PER_STG = 2,
  parameter int TAG_W       = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  shift_pipe_if.slave bus
);
  localparam int N = $clog2(WIDTH);
  localparam int S = (N + LVL_PER_STG - 1) / LVL_PER_STG;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_PIPE_ROTATE_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  logic             advance;
  logic             valid_q [S];
  logic             valid_d [S];
  logic [WIDTH-1:0] data_q  [S];
  logic [WIDTH-1:0] data_d  [S];
  logic [N-1:0]     shamt_q [S];
  logic [N-1:0]     shamt_d [S];
  logic [1:0]       op_q    [S];
  logic [1:0]       op_d    [S];
  logic [TAG_W-1:0] tag_q   [S];
  logic [TAG_W-1:0] tag_d   [S];
  logic             sign_q  [S];
  logic             sign_d  [S];
  logic             zero_q;
  logic             zero_d;

  // One log2 level: right shifts pull in `ext` from above, so the fill source picks the op.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input int               k,
    input logic [1:0]       op,
    input logic             sign
  );
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0]   ext;
    logic [WIDTH-1:0]   res;
    ext = '0;
    if (op == OP_SRA) begin
      ext = {WIDTH{sign}};
    end
`ifdef SHIFT_PIPE_ROTATE_EN
    if (op == OP_ROR) begin
      ext = d;
    end
`endif
    wide = {ext, d} >> (1 << k);
    res  = wide[WIDTH-1:0];
    if (op == OP_SLL) begin
      res = d << (1 << k);
    end
    return res;
  endfunction

  assign advance      = !valid_q[S-1] || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar gi = 0; gi < S; gi++) begin : g_stage
    localparam int LO = gi * LVL_PER_STG;
    localparam int HI = (LO + LVL_PER_STG < N) ? (LO + LVL_PER_STG) : N;

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [N-1:0]     src_shamt;
    logic [1:0]       src_op;
    logic [TAG_W-1:0] src_tag;
    logic             src_sign;
    logic [WIDTH-1:0] lvl_data;

    if (gi == 0) begin : g_head
      // The sign is captured once here so later SRA levels never depend on partial data.
      assign src_valid = bus.in_valid;
      assign src_data  = bus.in_data;
      assign src_shamt = bus.in_shamt;
      assign src_op    = bus.in_op;
      assign src_tag   = bus.in_tag;
      assign src_sign  = bus.in_data[WIDTH-1];
    end else begin : g_body
      assign src_valid = valid_q[gi-1];
      assign src_data  = data_q[gi-1];
      assign src_shamt = shamt_q[gi-1];
      assign src_op    = op_q[gi-1];
      assign src_tag   = tag_q[gi-1];
      assign src_sign  = sign_q[gi-1];
    end

    always_comb begin
      lvl_data = src_data;
      for (int k = LO; k < HI; k++) begin
        if (src_shamt[k]) begin
          lvl_data = shift_level(lvl_data, k, src_op, src_sign);
        end
      end
    end

    assign valid_d[gi] = src_valid;
    assign data_d[gi]  = lvl_data;
    assign shamt_d[gi] = src_shamt;
    assign op_d[gi]    = src_op;
    assign tag_d[gi]   = src_tag;
    assign sign_d[gi]  = src_sign;
  end

  assign zero_d = (data_d[S-1] == '0);

  // The whole pipe advances or holds together; bubbles travel like real entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < S; s++) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= '0;
        tag_q[s]   <= '0;
        sign_q[s]  <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int s = 0; s < S; s++) begin
        valid_q[s] <= valid_d[s];
        data_q[s]  <= data_d[s];
        shamt_q[s] <= shamt_d[s];
        op_q[s]    <= op_d[s];
        tag_q[s]   <= tag_d[s];
        sign_q[s]  <= sign_d[s];
      end
      zero_q <= zero_d;
    end
  end

  assign bus.out_valid = valid_q[S-1];
  assign bus.out_data  = data_q[S-1];
  assign bus.out_tag   = tag_q[S-1];
  assign bus.out_zero  = zero_q;

  // Control fields of the last stage have no consumer.
  logic unused_last_stage;
  assign unused_last_stage = ^{shamt_q[S-1], op_q[S-1], sign_q[S-1]};
endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed 32-bit cases, backpressure, reset mid-flight,
// and random sweeps on 8-bit (S=3) and 64-bit (S=1) instances against an arithmetic model.
module tb_shift_pipe;
  localparam int TAG_W = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clock = ~clock;

  shift_pipe_if #(.WIDTH(32), .TAG_W(TAG_W)) bus32 ();
  shift_pipe_if #(.WIDTH(8),  .TAG_W(TAG_W)) bus8 ();
  shift_pipe_if #(.WIDTH(64), .TAG_W(TAG_W)) bus64 ();

  shift_pipe #(.WIDTH(32), .LVL_PER_STG(2), .TAG_W(TAG_W)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .bus(bus32.slave));
  shift_pipe #(.WIDTH(8), .LVL_PER_STG(1), .TAG_W(TAG_W)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .bus(bus8.slave));
  shift_pipe #(.WIDTH(64), .LVL_PER_STG(6), .TAG_W(TAG_W)) u_dut64 (
    .clock(clock), .reset_n(reset_n), .bus(bus64.slave));

  // Reference: whole-amount shift on a w-bit value using plain arithmetic.
  function automatic logic [63:0] ref_shift(input int w, input logic [63:0] d, input int sh,
                                            input logic [1:0] op);
    logic [63:0] mask;
    logic [63:0] v;
    logic [63:0] r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = d & mask;
    case (op)
      2'b00: r = (v << sh) & mask;
      2'b10: begin
        r = v >> sh;
        if (v[w-1]) r = r | (mask & ~(mask >> sh));
      end
`ifdef SHIFT_PIPE_ROTATE_EN
      2'b11: r = ((v >> sh) | (v << (w - sh))) & mask;
`endif
      default: r = v >> sh;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit instance, measure latency, check the result.
  task automatic op32(input string name, input logic [31:0] d, input int sh, input logic [1:0] op,
                      input logic [3:0] tag, input logic [31:0] exp);
    int n;
    @(negedge clock);
    bus32.in_valid  = 1'b1;
    bus32.in_data   = d;
    bus32.in_shamt  = 5'(sh);
    bus32.in_op     = op;
    bus32.in_tag    = tag;
    bus32.out_ready = 1'b1;
    @(negedge clock);
    bus32.in_valid = 1'b0;
    n = 1;
    while (!bus32.out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({name, "_lat"},  64'(n), 64'd3);
    check({name, "_data"}, 64'(bus32.out_data), 64'(exp));
    check({name, "_zero"}, 64'(bus32.out_zero), 64'(exp == 32'd0));
    check({name, "_tag"},  64'(bus32.out_tag), 64'(tag));
    $display("op32 %s data=%08h sh=%0d op=%0d -> %08h lat=%0d", name, d, sh, op, bus32.out_data, n);
  endtask

  logic [63:0] exp_q[$];
  logic [3:0]  tagx_q[$];
  logic [63:0] exp8_q[$];
  logic [3:0]  tag8_q[$];
  logic [63:0] exp64_q[$];
  logic [3:0]  tag64_q[$];

  initial begin
    logic [63:0] d;
    logic [63:0] d8;
    logic [63:0] d64;
    int          sh, sh8, sh64;
    logic [1:0]  op, op8, op64;
    int          issued, got, cyc, sent8, got8, sent64, got64;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic [3:0]  prev_tag;
    logic        prev_zero;

    bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_shamt = '0; bus32.in_op = '0;
    bus32.in_tag = '0; bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_shamt = '0; bus8.in_op = '0;
    bus8.in_tag = '0; bus8.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_shamt = '0; bus64.in_op = '0;
    bus64.in_tag = '0; bus64.out_ready = 1'b1;

    repeat (3) @(negedge clock);
    check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus32.in_ready),  64'd1);
    check("rst_out_data",  64'(bus32.out_data),  64'd0);
    check("rst_out_tag",   64'(bus32.out_tag),   64'd0);
    check("rst_out_zero",  64'(bus32.out_zero),  64'd0);
    check("rst_valid8",    64'(bus8.out_valid),  64'd0);
    check("rst_valid64",   64'(bus64.out_valid), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_valid", 64'(bus32.out_valid), 64'd0);
    check("post_rst_ready", 64'(bus32.in_ready),  64'd1);
    $display("reset checks done");

    op32("sra_fill", 32'h8000_00F0, 4, 2'b10, 4'h1, 32'hF800_000F);
    op32("srl_fill", 32'h8000_00F0, 4, 2'b01, 4'h2, 32'h0800_000F);
    op32("sll_31",   32'h0000_0001, 31, 2'b00, 4'h3, 32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      op = 2'(i);
      op32("sh0", 32'h1234_5678, 0, op, 4'(4 + i), 32'h1234_5678);
    end
`ifdef SHIFT_PIPE_ROTATE_EN
    op32("ror_4", 32'h0000_00A5, 4, 2'b11, 4'h8, 32'h5000_000A);
`else
    op32("ror_4", 32'h0000_00A5, 4, 2'b11, 4'h8, 32'h0000_000A);
`endif
    op32("zero_res", 32'h0000_000F, 4, 2'b01, 4'h9, 32'h0000_0000);
    for (int i = 0; i < 8; i++) begin
      d  = 64'($urandom);
      sh = int'($urandom_range(0, 31));
      op = 2'($urandom_range(0, 3));
      op32("rnd32", d[31:0], sh, op, 4'(i), 32'(ref_shift(32, d, sh, op)));
    end

    // Backpressure: six ops with tags 0..5 while out_ready follows 1,0,0,...
    issued = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_tag = '0; prev_zero = 1'b0;
    while (got < 6 && cyc < 60) begin
      @(negedge clock);
      if (prev_stall) begin
        check("bp_hold_data", 64'(bus32.out_data), prev_data);
        check("bp_hold_tag",  64'(bus32.out_tag),  64'(prev_tag));
        check("bp_hold_zero", 64'(bus32.out_zero), 64'(prev_zero));
      end
      bus32.out_ready = (cyc % 3 == 0);
      d = 64'($urandom); sh = int'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
      bus32.in_valid = (issued < 6);
      bus32.in_data  = d[31:0];
      bus32.in_shamt = 5'(sh);
      bus32.in_op    = op;
      bus32.in_tag   = 4'(issued);
      #1;
      if (bus32.out_valid) begin
        check("bp_in_ready", 64'(bus32.in_ready), 64'(bus32.out_ready));
        if (bus32.out_ready) begin
          check("bp_queue_nonempty", 64'(tagx_q.size() > 0), 64'd1);
          if (tagx_q.size() > 0) begin
            check("bp_tag",  64'(bus32.out_tag),  64'(tagx_q.pop_front()));
            check("bp_data", 64'(bus32.out_data), exp_q.pop_front());
            $display("bp out tag=%0d data=%08h cyc=%0d", bus32.out_tag, bus32.out_data, cyc);
          end
          got++;
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        exp_q.push_back(ref_shift(32, d, sh, op));
        tagx_q.push_back(4'(issued));
        issued++;
      end
      prev_stall = bus32.out_valid && !bus32.out_ready;
      prev_data  = 64'(bus32.out_data);
      prev_tag   = bus32.out_tag;
      prev_zero  = bus32.out_zero;
      cyc++;
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    check("bp_count", 64'(got), 64'd6);
    check("bp_leftover", 64'(tagx_q.size()), 64'd0);

    // Reset mid-flight: three ops accepted, reset lands before the first result is taken.
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      bus32.in_valid = 1'b1;
      bus32.in_data  = $urandom;
      bus32.in_shamt = 5'($urandom_range(0, 31));
      bus32.in_op    = 2'($urandom_range(0, 3));
      bus32.in_tag   = 4'(10 + i);
      if (i < 2) @(negedge clock);
    end
    @(posedge clock);
    #1;
    reset_n        = 1'b0;
    bus32.in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus32.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus32.in_ready),  64'd1);
    check("mid_rst_tag",   64'(bus32.out_tag),   64'd0);
    check("mid_rst_data",  64'(bus32.out_data),  64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("no_stale", 64'(bus32.out_valid), 64'd0);
    end
    $display("mid-flight reset checks done");
    op32("post_mid_rst", 32'hC000_0001, 1, 2'b10, 4'hE, 32'hE000_0000);

    // Random sweep on the 8-bit and 64-bit instances with random backpressure.
    sent8 = 0; got8 = 0; sent64 = 0; got64 = 0;
    for (int c = 0; c < 400 && (got8 < 40 || got64 < 40); c++) begin
      @(negedge clock);
      bus8.out_ready  = ($urandom_range(0, 3) != 0);
      bus64.out_ready = ($urandom_range(0, 3) != 0);
      d8 = 64'($urandom); sh8 = int'($urandom_range(0, 7)); op8 = 2'($urandom_range(0, 3));
      d64 = {$urandom, $urandom}; sh64 = int'($urandom_range(0, 63)); op64 = 2'($urandom_range(0, 3));
      bus8.in_valid  = (sent8 < 40);
      bus8.in_data   = d8[7:0];
      bus8.in_shamt  = 3'(sh8);
      bus8.in_op     = op8;
      bus8.in_tag    = 4'(sent8);
      bus64.in_valid = (sent64 < 40);
      bus64.in_data  = d64;
      bus64.in_shamt = 6'(sh64);
      bus64.in_op    = op64;
      bus64.in_tag   = 4'(sent64);
      #1;
      if (bus8.out_valid && bus8.out_ready) begin
        check("sw8_nonempty", 64'(exp8_q.size() > 0), 64'd1);
        if (exp8_q.size() > 0) begin
          d = exp8_q.pop_front();
          check("sw8_data", 64'(bus8.out_data), d);
          check("sw8_zero", 64'(bus8.out_zero), 64'(d == 64'd0));
          check("sw8_tag",  64'(bus8.out_tag),  64'(tag8_q.pop_front()));
          $display("sw8 out tag=%0d data=%02h", bus8.out_tag, bus8.out_data);
        end
        got8++;
      end
      if (bus64.out_valid && bus64.out_ready) begin
        check("sw64_nonempty", 64'(exp64_q.size() > 0), 64'd1);
        if (exp64_q.size() > 0) begin
          d = exp64_q.pop_front();
          check("sw64_data", bus64.out_data, d);
          check("sw64_zero", 64'(bus64.out_zero), 64'(d == 64'd0));
          check("sw64_tag",  64'(bus64.out_tag),  64'(tag64_q.pop_front()));
          $display("sw64 out tag=%0d data=%016h", bus64.out_tag, bus64.out_data);
        end
        got64++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        exp8_q.push_back(ref_shift(8, d8, sh8, op8));
        tag8_q.push_back(4'(sent8));
        sent8++;
      end
      if (bus64.in_valid && bus64.in_ready) begin
        exp64_q.push_back(ref_shift(64, d64, sh64, op64));
        tag64_q.push_back(4'(sent64));
        sent64++;
      end
    end
    bus8.in_valid  = 1'b0;
    bus64.in_valid = 1'b0;
    check("sw8_count",  64'(got8),  64'd40);
    check("sw64_count", 64'(got64), 64'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the ALU datapath, superseding the fixed 32-bit arithmetic-right-only shifter.
- Supports logical left, logical right, arithmetic right and (optionally) rotate right on a WIDTH-bit operand.
- Uses a valid/ready handshake with backpressure on both sides, and carries a user tag alongside each operation.
- Sits between operand fetch and the ALU result mux; results return in issue order.

## Interface
- WIDTH, 32: operand width; must be a power of two, minimum 8.
- LVL_PER_STG, 2: number of log2 shift levels evaluated per pipeline stage; range 1..log2(WIDTH).
- TAG_W, 4: width of the sideband tag carried with each operation.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted on this cycle when in_valid && in_ready.
- in_data  in  WIDTH  operand.
- in_shamt  in  log2(WIDTH)  shift amount; all values 0..WIDTH-1 are legal.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  opaque tag; returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  out_data == 0.

## Operation
- Levels: there are N = log2(WIDTH) shift levels. Level k shifts by 2^k when shamt[k] is set. Levels run from k=0 upward.
- Stages: levels are grouped LVL_PER_STG per stage, giving S = ceil(N/LVL_PER_STG) register stages. The final stage register drives the out_* ports.
- State per stage: valid bit, partial data, remaining shamt bits, op, tag, and the captured sign bit (the operand MSB at acceptance).
- Sign fill: SRA fills vacated bits with the captured sign bit. SLL and SRL fill with 0. ROR wraps the bits shifted out of bit 0 into the MSB.
- shamt = 0 returns in_data unchanged for every op.
- out_zero is computed from the final-stage data and registered with it.
- Flow control: the pipeline moves as one unit, with advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance is high, every stage loads from the stage before it. Stage 0 loads in_valid && in_ready together with the request fields.
  - When advance is low, all stages hold.
  - Bubbles are not collapsed.
- Simultaneous accept and emit on the same cycle is legal and is the sustained mode: one result per cycle.
- Results leave in the order requests were accepted. Tags are never reordered.

## Timing
- Latency: S cycles from the accepting edge to out_valid, given no stall. Defaults give S = ceil(5/2) = 3.
- Throughput: 1 operation per cycle while out_ready is held high.
- in_ready is combinational from out_ready and out_valid. No other input-to-output combinational path exists.
- Reset:
  - Asserting reset_n low clears all stage valid bits asynchronously, so out_valid = 0.
  - out_data, out_tag and out_zero reset to 0 (out_zero resets to 0, not 1).
  - in_ready = 1 during and after reset, because out_valid = 0.
- Reset mid-operation drops all in-flight operations. Nothing is replayed.
- Stall: while out_valid && !out_ready, out_data, out_tag and out_zero stay stable, and in_ready = 0.
- Payload inputs are sampled only on an accepting edge. Their values are don't-care otherwise.

## Configuration
- SHIFT_PIPE_ROTATE_EN defined: op 11 performs rotate right by shamt, using the wrap path in every level.
- SHIFT_PIPE_ROTATE_EN undefined:
  - No wrap logic is instantiated.
  - op 11 executes exactly as SRL (01), zero fill.
  - All other behaviour is unchanged.

## Test plan
- SRA sign fill: WIDTH=32, data 0x8000_00F0, shamt 4, op 10 -> out_data 0xF800_000F after 3 cycles, out_zero 0; same data with op 01 -> 0x0800_000F.
- SLL boundaries: data 0x0000_0001, op 00, shamt 31 -> 0x8000_0000; data 0x1234_5678, any op, shamt 0 -> 0x1234_5678.
- Rotate right:
  - With the macro: data 0x0000_00A5, op 11, shamt 4 -> 0x5000_000A.
  - Without the macro: same stimulus -> 0x0000_000A.
- Backpressure and order: issue 6 back-to-back ops with tags 0..5 while out_ready toggles 1,0,0,1,...
  - Every tag emerges exactly once, in order 0..5.
  - out_data and out_tag are stable on every stalled cycle.
  - in_ready equals out_ready on every cycle where out_valid is high.
- Reset mid-flight: accept 3 ops, then assert reset_n low for 1 cycle before the first result.
  - out_valid is 0 immediately, and no stale results appear afterwards.
  - The next op returns after exactly 3 cycles.
- Parameter sweep: WIDTH=8, LVL_PER_STG=1 (S=3), random ops and shamt 0..7 checked against a reference model; also WIDTH=64, LVL_PER_STG=6 (S=1).
